// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: the pipeline writeback always wins; multi-cycle results wait in an
// in-order queue and drain on idle port cycles. Queued registers are reported busy for decode.
module grf_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p_we,
  input  logic [4:0]               p_a3,
  input  logic [31:0]              p_wd,
  input  logic [31:0]              p_pc,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [4:0]               m_a3,
  input  logic [31:0]              m_wd,
  input  logic [31:0]              m_pc,
  input  logic [4:0]               q_rs,
  input  logic [4:0]               q_rt,
  output logic                     q_busy_rs,
  output logic                     q_busy_rt,
  output logic                     grf_we,
  output logic [4:0]               grf_a3,
  output logic [31:0]              grf_wd,
  output logic [31:0]              grf_pc,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: an m-result transfers on a rising edge where m_valid && m_ready.
  // m_ready depends only on occupancy and reset, never on m_valid or a same-cycle dequeue.

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       a3_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];

  logic full, empty, p_wr, head_live, enq, deq;
  logic busy_rs_st, busy_rt_st;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign p_wr      = p_we && (p_a3 != 5'd0);
  assign head_live = !empty && live_q[head_q];
  assign m_ready   = !full && !reset;
  assign enq       = m_valid && m_ready;
  // A live head yields to the pipeline; a dead head is dropped on any cycle.
  assign deq       = !reset && !empty && !(head_live && p_wr);
  assign pending   = count_q;

  always_comb begin
    grf_we = 1'b0;
    grf_a3 = 5'd0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (!reset) begin
      if (p_wr) begin
        grf_we = 1'b1;
        grf_a3 = p_a3;
        grf_wd = p_wd;
        grf_pc = p_pc;
      end else if (head_live) begin
        grf_we = 1'b1;
        grf_a3 = a3_q[head_q];
        grf_wd = wd_q[head_q];
        grf_pc = pc_q[head_q];
      end
    end
  end

  // Supersede stored entries first; the entry enqueued this edge is younger and is written last.
  always_comb begin
    live_d = live_q;
    if (p_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (a3_q[i] == p_a3) live_d[i] = 1'b0;
      end
    end
    if (deq) live_d[head_q] = 1'b0;
    if (enq) live_d[tail_q] = (m_a3 != 5'd0);
  end

  always_comb begin
    head_d  = deq ? AW'(head_q + 1'b1) : head_q;
    tail_d  = enq ? AW'(tail_q + 1'b1) : tail_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    busy_rs_st = 1'b0;
    busy_rt_st = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (a3_q[i] == q_rs)) busy_rs_st = 1'b1;
      if (live_q[i] && (a3_q[i] == q_rt)) busy_rt_st = 1'b1;
    end
  end

  assign q_busy_rs = !reset && (q_rs != 5'd0) && (busy_rs_st || (m_valid && (m_a3 == q_rs)));
  assign q_busy_rt = !reset && (q_rt != 5'd0) && (busy_rt_st || (m_valid && (m_a3 == q_rt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      live_q  <= live_d;
    end
  end

  // Payload needs no reset: it is only observed through live/occupancy.
  always_ff @(posedge clk) begin
    if (enq) begin
      a3_q[tail_q] <= m_a3;
      wd_q[tail_q] <= m_wd;
      pc_q[tail_q] <= m_pc;
    end
  end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: hand-computed expectations for each test-plan scenario.
module tb_grf_wb_arbiter;
  logic        clk;
  logic        reset;
  logic        p_we;
  logic [4:0]  p_a3;
  logic [31:0] p_wd, p_pc;
  logic        m_valid, m_ready;
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_pc;
  logic [4:0]  q_rs, q_rt;
  logic        q_busy_rs, q_busy_rt;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;
  logic [2:0]  pending;

  int total = 0;
  int bad   = 0;

  grf_wb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
    .q_rs(q_rs), .q_rt(q_rt), .q_busy_rs(q_busy_rs), .q_busy_rt(q_busy_rt),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .pending(pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    p_we = 0; p_a3 = 0; p_wd = 0; p_pc = 0;
    m_valid = 0; m_a3 = 0; m_wd = 0; m_pc = 0;
  endtask

  task automatic drive_p(input logic en, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    p_we = en; p_a3 = a3; p_wd = wd; p_pc = pc;
  endtask

  task automatic drive_m(input logic v, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    m_valid = v; m_a3 = a3; m_wd = wd; m_pc = pc;
  endtask

  initial begin
    idle_inputs();
    q_rs = 0; q_rt = 0;
    reset = 1'b1;
    step();
    step();

    // reset state, pipeline write during reset is dropped
    drive_p(1, 5'd4, 32'h44, 32'h40);
    settle();
    check("rst_grf_we", 32'(grf_we), 0);
    check("rst_m_ready", 32'(m_ready), 0);
    check("rst_pending", 32'(pending), 0);
    step();
    idle_inputs();
    reset = 1'b0;
    settle();
    check("idle_m_ready", 32'(m_ready), 1);
    check("idle_grf_we", 32'(grf_we), 0);

    // single m-write $5
    drive_m(1, 5'd5, 32'h11, 32'h3000);
    q_rs = 5; q_rt = 5;
    settle();
    check("t1_busy_inflight", 32'(q_busy_rs), 1);
    check("t1_grf_we_pre", 32'(grf_we), 0);
    step();
    drive_m(0, 0, 0, 0);
    settle();
    check("t1_pending1", 32'(pending), 1);
    check("t1_grf_we", 32'(grf_we), 1);
    check("t1_grf_a3", 32'(grf_a3), 5);
    check("t1_grf_wd", grf_wd, 32'h11);
    check("t1_grf_pc", grf_pc, 32'h3000);
    step();
    settle();
    check("t1_pending0", 32'(pending), 0);
    check("t1_grf_we_post", 32'(grf_we), 0);
    check("t1_grf_a3_idle", 32'(grf_a3), 0);
    check("t1_busy_post", 32'(q_busy_rt), 0);

    // p_we on $8 for 3 cycles, $9 accepted in the first
    q_rs = 9; q_rt = 9;
    drive_p(1, 5'd8, 32'h80, 32'h100);
    drive_m(1, 5'd9, 32'h22, 32'h200);
    settle();
    check("t2_p_a3", 32'(grf_a3), 8);
    check("t2_p_wd", grf_wd, 32'h80);
    check("t2_p_pc", grf_pc, 32'h100);
    step();
    drive_m(0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      settle();
      check("t2_hold_a3", 32'(grf_a3), 8);
      check("t2_busy_rs", 32'(q_busy_rs), 1);
      check("t2_busy_rt", 32'(q_busy_rt), 1);
      check("t2_pending", 32'(pending), 1);
      step();
    end
    drive_p(0, 0, 0, 0);
    settle();
    check("t2_m_we", 32'(grf_we), 1);
    check("t2_m_a3", 32'(grf_a3), 9);
    check("t2_m_wd", grf_wd, 32'h22);
    check("t2_busy_last", 32'(q_busy_rs), 1);
    step();
    settle();
    check("t2_busy_clear", 32'(q_busy_rs), 0);
    check("t2_pending0", 32'(pending), 0);

    // fill under continuous p_we, then drain in FIFO order
    drive_p(1, 5'd8, 32'h88, 32'h104);
    for (int i = 0; i < 4; i++) begin
      drive_m(1, 5'(10 + i), 32'h100 + i, 32'h400 + 4 * i);
      settle();
      check("t3_fill_ready", 32'(m_ready), 1);
      step();
    end
    drive_m(1, 5'd20, 32'hdead, 32'h500);
    settle();
    check("t3_full_ready", 32'(m_ready), 0);
    check("t3_full_pending", 32'(pending), 4);
    step();
    check("t3_refused_pending", 32'(pending), 4);
    drive_p(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      if (i == 0) check("t3_drain_ready0", 32'(m_ready), 0);
      check("t3_drain_we", 32'(grf_we), 1);
      check("t3_drain_a3", 32'(grf_a3), 10 + i);
      check("t3_drain_wd", grf_wd, 32'h100 + i);
      check("t3_drain_pc", grf_pc, 32'h400 + 4 * i);
      step();
      drive_m(0, 0, 0, 0);
      if (i == 0) begin
        settle();
        check("t3_ready_back", 32'(m_ready), 1);
        check("t3_pending3", 32'(pending), 3);
      end
    end
    settle();
    check("t3_pending0", 32'(pending), 0);

    // supersede $3
    q_rs = 3; q_rt = 0;
    drive_m(1, 5'd3, 32'hAA, 32'h600);
    step();
    drive_m(0, 0, 0, 0);
    drive_p(1, 5'd3, 32'hBB, 32'h604);
    settle();
    check("t4_p_wd", grf_wd, 32'hBB);
    check("t4_busy_pre", 32'(q_busy_rs), 1);
    check("t4_busy_rt0", 32'(q_busy_rt), 0);
    step();
    drive_p(0, 0, 0, 0);
    settle();
    check("t4_dead_we", 32'(grf_we), 0);
    check("t4_busy_post", 32'(q_busy_rs), 0);
    check("t4_pending1", 32'(pending), 1);
    step();
    settle();
    check("t4_pending0", 32'(pending), 0);
    check("t4_we_end", 32'(grf_we), 0);

    // write to $0, then dead head dropped while the pipeline writes
    q_rs = 0;
    drive_m(1, 5'd0, 32'h55, 32'h700);
    settle();
    check("t5_busy_r0", 32'(q_busy_rs), 0);
    step();
    drive_m(0, 0, 0, 0);
    settle();
    check("t5_we", 32'(grf_we), 0);
    check("t5_pending1", 32'(pending), 1);
    check("t5_busy_r0_q", 32'(q_busy_rs), 0);
    step();
    settle();
    check("t5_pending0", 32'(pending), 0);
    drive_m(1, 5'd0, 32'h56, 32'h704);
    step();
    drive_m(1, 5'd6, 32'h66, 32'h708);
    drive_p(1, 5'd7, 32'h77, 32'h70c);
    step();
    drive_m(0, 0, 0, 0);
    drive_p(0, 0, 0, 0);
    settle();
    check("t5_enq_deq_pending", 32'(pending), 1);
    check("t5_m6_a3", 32'(grf_a3), 6);
    check("t5_m6_wd", grf_wd, 32'h66);
    step();
    settle();
    check("t5_pending_end", 32'(pending), 0);

    // reset mid-queue
    drive_p(1, 5'd8, 32'h8, 32'h800);
    for (int i = 0; i < 3; i++) begin
      drive_m(1, 5'(11 + i), 32'h200 + i, 32'h900);
      step();
    end
    drive_m(0, 0, 0, 0);
    settle();
    check("t6_pending3", 32'(pending), 3);
    q_rs = 11;
    reset = 1'b1;
    settle();
    check("t6_rst_we", 32'(grf_we), 0);
    check("t6_rst_ready", 32'(m_ready), 0);
    check("t6_rst_busy", 32'(q_busy_rs), 0);
    step();
    settle();
    check("t6_pending0", 32'(pending), 0);
    check("t6_we0", 32'(grf_we), 0);
    reset = 1'b0;
    drive_p(0, 0, 0, 0);
    settle();
    check("t6_ready1", 32'(m_ready), 1);
    check("t6_busy0", 32'(q_busy_rs), 0);
    check("t6_we_after", 32'(grf_we), 0);
    step();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
